// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the core load/store path and a
// debug/loader master; the core has priority, starvation forces a debug grant.
//
// state  | meaning
// S_CORE | core owns the port; a pending debug request ages in wait_cnt
// S_DBG  | debug access on the port for one cycle, core stalled
// S_ACK  | dbg_ack pulse, core owns the port again and is unstalled
module dmem_port_arbiter #(
  parameter int MAX_WAIT = 8,
  parameter int WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_we,
  input  logic        core_re,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wd,
  output logic [31:0] core_rd,
  output logic        core_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wd,
  output logic        dbg_ack,
  output logic [31:0] dbg_rd,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    S_CORE = 2'd0,
    S_DBG  = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]       dbg_rd_q;
  logic              core_busy;

  assign core_busy = core_we | core_re;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_CORE;
      wait_cnt_q <= '0;
      dbg_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (state_q == S_DBG && !dbg_we)
        dbg_rd_q <= mem_rd;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    case (state_q)
      S_CORE: begin
        if (dbg_req) begin
          if (!core_busy || wait_cnt_q >= WAIT_LAST)
            state_d = S_DBG;
          else
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_DBG:   state_d = S_ACK;
      S_ACK:   state_d = S_CORE;
      default: state_d = S_CORE;
    endcase
  end

  // dmem may still write on the reset edge, so the write enable is gated by reset
  always_comb begin
    mem_we = 1'b0;
    mem_a  = core_addr;
    mem_wd = core_wd;
    if (state_q == S_DBG) begin
      mem_a  = dbg_addr;
      mem_wd = dbg_wd;
      mem_we = dbg_we & ~reset;
    end else begin
      mem_we = core_we & ~reset;
    end
  end

  assign core_rd    = mem_rd;
  assign core_stall = (state_q == S_DBG);
  assign dbg_ack    = (state_q == S_ACK);
  assign dbg_rd     = dbg_rd_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural dmem model and an
// expectation queue popped at each sampling point.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_we, core_re;
  logic [31:0] core_addr, core_wd, core_rd;
  logic        core_stall;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wd;
  logic        dbg_ack;
  logic [31:0] dbg_rd;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  logic [31:0] mem [0:255];
  logic        mem_clear;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  dmem_port_arbiter #(.MAX_WAIT(8), .WAIT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .core_we    (core_we),
    .core_re    (core_re),
    .core_addr  (core_addr),
    .core_wd    (core_wd),
    .core_rd    (core_rd),
    .core_stall (core_stall),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wd     (dbg_wd),
    .dbg_ack    (dbg_ack),
    .dbg_rd     (dbg_rd),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[9:2]];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_a[9:2]] <= mem_wd;
    end
  end

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_mis++;
      $error("FAIL scoreboard_empty: observed %h with no expected value", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        n_mis++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_clear = 1'b1;
    core_we = 1'b0; core_re = 1'b0; core_addr = '0; core_wd = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wd = '0;
    cyc(); cyc();
    reset = 1'b0; mem_clear = 1'b0;
    #1;
    expect_val("rst_stall", 32'd0);  check({31'd0, core_stall});
    expect_val("rst_ack",   32'd0);  check({31'd0, dbg_ack});
    expect_val("rst_dbg_rd", 32'd0); check(dbg_rd);
    expect_val("rst_mem_we", 32'd0); check({31'd0, mem_we});

    // debug write to an idle core
    cyc();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h40; dbg_wd = 32'hDEADBEEF;
    expect_val("w_req_stall", 32'd0); #1 check({31'd0, core_stall});
    cyc();
    expect_val("w_dbg_stall", 32'd1);
    expect_val("w_dbg_we",    32'd1);
    expect_val("w_dbg_a",     32'h40);
    expect_val("w_dbg_wd",    32'hDEADBEEF);
    expect_val("w_dbg_noack", 32'd0);
    #1;
    check({31'd0, core_stall}); check({31'd0, mem_we}); check(mem_a); check(mem_wd);
    check({31'd0, dbg_ack});
    cyc();
    dbg_req = 1'b0;
    expect_val("w_ack",       32'd1);
    expect_val("w_ack_stall", 32'd0);
    #1 check({31'd0, dbg_ack}); check({31'd0, core_stall});
    cyc();
    core_re = 1'b1; core_addr = 32'h40;
    expect_val("w_ack_drop", 32'd0);
    expect_val("w_core_rd",  32'hDEADBEEF);
    #1 check({31'd0, dbg_ack}); check(core_rd);
    core_re = 1'b0;

    // debug read to an idle core
    cyc();
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40;
    cyc();
    expect_val("r_dbg_we",    32'd0);
    expect_val("r_dbg_stall", 32'd1);
    #1 check({31'd0, mem_we}); check({31'd0, core_stall});
    cyc();
    dbg_req = 1'b0;
    expect_val("r_ack",    32'd1);
    expect_val("r_dbg_rd", 32'hDEADBEEF);
    #1 check({31'd0, dbg_ack}); check(dbg_rd);
    cyc();
    expect_val("r_hold_ack", 32'd0);
    expect_val("r_hold_rd",  32'hDEADBEEF);
    #1 check({31'd0, dbg_ack}); check(dbg_rd);

    // starvation: core load held busy, forced grant after MAX_WAIT cycles
    cyc();
    core_re = 1'b1; core_addr = 32'h200;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      expect_val($sformatf("starve_stall_%0d", k), {31'd0, k == 8});
      expect_val($sformatf("starve_ack_%0d", k),   {31'd0, k == 9});
      expect_val($sformatf("starve_a_%0d", k),     (k == 8) ? 32'h40 : 32'h200);
      #1 check({31'd0, core_stall}); check({31'd0, dbg_ack}); check(mem_a);
      if (k == 9) dbg_req = 1'b0;
    end

    // request withdrawn after 3 waits; the counter must restart on re-raise
    cyc();
    dbg_req = 1'b1;
    cyc(); cyc(); cyc();
    dbg_req = 1'b0;
    cyc();
    expect_val("wd_gap_stall", 32'd0); #1 check({31'd0, core_stall});
    cyc();
    dbg_req = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      expect_val($sformatf("rearm_stall_%0d", k), {31'd0, k == 8});
      expect_val($sformatf("rearm_ack_%0d", k),   {31'd0, k == 9});
      #1 check({31'd0, core_stall}); check({31'd0, dbg_ack});
      if (k == 9) dbg_req = 1'b0;
    end
    core_re = 1'b0;

    // core store collides with the debug write slot and is replayed
    cyc();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h80; dbg_wd = 32'h22;
    cyc();
    core_we = 1'b1; core_addr = 32'h80; core_wd = 32'h11;
    expect_val("col_stall", 32'd1);
    expect_val("col_wd",    32'h22);
    #1 check({31'd0, core_stall}); check(mem_wd);
    cyc();
    dbg_req = 1'b0;
    expect_val("col_mem_dbg", 32'h22);
    expect_val("col_replay_we", 32'd1);
    expect_val("col_replay_wd", 32'h11);
    #1 check(mem[32]); check({31'd0, mem_we}); check(mem_wd);
    cyc();
    core_we = 1'b0;
    expect_val("col_mem_core", 32'h11); #1 check(mem[32]);

    // reset during a debug write: no commit, no ack
    cyc();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h100; dbg_wd = 32'hCAFEF00D;
    cyc();
    reset = 1'b1;
    expect_val("rstdbg_we", 32'd0); #1 check({31'd0, mem_we});
    cyc();
    reset = 1'b0; dbg_req = 1'b0;
    expect_val("rstdbg_stall", 32'd0);
    expect_val("rstdbg_ack",   32'd0);
    expect_val("rstdbg_mem",   32'd0);
    #1 check({31'd0, core_stall}); check({31'd0, dbg_ack}); check(mem[64]);
    cyc();
    expect_val("rstdbg_ack2", 32'd0); #1 check({31'd0, dbg_ack});

    // reset during the ack cycle clears the ack next cycle
    cyc();
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h80;
    cyc(); cyc();
    dbg_req = 1'b0;
    expect_val("rstack_ack", 32'd1); #1 check({31'd0, dbg_ack});
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    expect_val("rstack_clear", 32'd0); #1 check({31'd0, dbg_ack});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
